light_sequencer: RTL

LIGHT_SEQUENCER -- requirements
Module: light_sequencer

---
 rtl/tlc_pkg.sv | 38 +++
 rtl/light_sequencer.sv | 102 ++++++++++
 2 files changed

// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared traffic-light encodings, states and default intervals
package tlc_pkg;

  localparam logic [1:0] LAMP_RED = 2'b00;
  localparam logic [1:0] LAMP_YEL = 2'b01;
  localparam logic [1:0] LAMP_GRN = 2'b10;

  localparam logic [3:0] T_BASE_DEF = 4'd6;
  localparam logic [3:0] T_EXT_DEF  = 4'd3;
  localparam logic [3:0] T_YEL_DEF  = 4'd2;

  typedef enum logic [2:0] {
    MAIN_G1,
    MAIN_G2,
    MAIN_Y,
    WALK,
    SIDE_G1,
    SIDE_G2,
    SIDE_Y
  } state_t;

  function automatic logic [1:0] main_lamp(state_t s);
    case (s)
      MAIN_G1, MAIN_G2: main_lamp = LAMP_GRN;
      MAIN_Y:           main_lamp = LAMP_YEL;
      default:          main_lamp = LAMP_RED;
    endcase
  endfunction

  function automatic logic [1:0] side_lamp(state_t s);
    case (s)
      SIDE_G1, SIDE_G2: side_lamp = LAMP_GRN;
      SIDE_Y:           side_lamp = LAMP_YEL;
      default:          side_lamp = LAMP_RED;
    endcase
  endfunction

endpackage

// File: rtl/light_sequencer.sv
// rtl/light_sequencer.sv - main/side/walk lamp sequencer driving an external interval timer
module light_sequencer
  import tlc_pkg::*;
#(
  parameter logic [3:0] T_BASE = T_BASE_DEF,
  parameter logic [3:0] T_EXT  = T_EXT_DEF,
  parameter logic [3:0] T_YEL  = T_YEL_DEF
) (
  input  logic       clk,
  input  logic       Reset_Sync,
  input  logic       sensor,
  input  logic       walk_btn,
  input  logic       expired,
  output logic       start_timer,
  output logic [3:0] Value,
  output logic [1:0] main_light,
  output logic [1:0] side_light,
  output logic       walk_lamp
);

  state_t     state_q, state_d;
  logic       start_q, start_d;
  logic [3:0] value_q, value_d;
  logic [1:0] main_q, main_d;
  logic [1:0] side_q, side_d;
  logic       walk_q, walk_d;
  logic       walk_pend_q, walk_pend_d;
  logic       armed_q, armed_d;
  logic       boot_q, boot_d;
  logic       go;

  // An expiry only counts once the timer has been reloaded for this state.
  assign go = armed_q & expired;

  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    walk_pend_d = walk_pend_q | walk_btn;
    start_d     = go | boot_q;
    armed_d     = armed_q | start_q;
    boot_d      = 1'b0;

    if (go) begin
      case (state_q)
        MAIN_G1: state_d = MAIN_G2;
        MAIN_G2: state_d = MAIN_Y;
        MAIN_Y:  state_d = walk_pend_q ? WALK : SIDE_G1;
        WALK:    state_d = SIDE_G1;
        SIDE_G1: state_d = sensor ? SIDE_G2 : SIDE_Y;
        SIDE_G2: state_d = SIDE_Y;
        SIDE_Y:  state_d = MAIN_G1;
        default: state_d = MAIN_G1;
      endcase

      case (state_d)
        MAIN_G1: value_d = T_BASE;
        MAIN_G2: value_d = sensor ? T_EXT : T_BASE;
        SIDE_G1: value_d = T_BASE;
        SIDE_G2: value_d = T_EXT;
        default: value_d = T_YEL;
      endcase

      armed_d = 1'b0;
      if (state_d == WALK) walk_pend_d = 1'b0;
    end

    main_d = main_lamp(state_d);
    side_d = side_lamp(state_d);
    walk_d = (state_d == WALK);
  end

  always_ff @(posedge clk or posedge Reset_Sync) begin
    if (Reset_Sync) begin
      state_q     <= MAIN_G1;
      start_q     <= 1'b0;
      value_q     <= T_BASE;
      main_q      <= LAMP_GRN;
      side_q      <= LAMP_RED;
      walk_q      <= 1'b0;
      walk_pend_q <= 1'b0;
      armed_q     <= 1'b0;
      boot_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      value_q     <= value_d;
      main_q      <= main_d;
      side_q      <= side_d;
      walk_q      <= walk_d;
      walk_pend_q <= walk_pend_d;
      armed_q     <= armed_d;
      boot_q      <= boot_d;
    end
  end

  assign start_timer = start_q;
  assign Value       = value_q;
  assign main_light  = main_q;
  assign side_light  = side_q;
  assign walk_lamp   = walk_q;

endmodule
